// File: rtl/irq_request_ctrl.sv
// irq_request_ctrl: synchronises the request lines and captures their rising edges
// as per-channel pending bits. The enabled pending set is arbitrated highest index
// first, and the winner is offered to the consumer over a valid/ready handshake.
// Build macro IRQ_OVERFLOW_EN adds sticky per-channel lost-event flags. When it is
// not defined, overflow is tied low and a repeat edge merges into the pending bit.
module irq_request_ctrl #(
  parameter int N_REQ       = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             irq_ready,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] sync_q [SYNC_STAGES];
  logic [N_REQ-1:0] sync_prev;
  logic [N_REQ-1:0] req_edge;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] ack_vec;
  logic [ID_W-1:0]  winner;
  logic             ack;

  // Synchronise the async request lines and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      sync_prev <= '0;
    end else begin
      sync_q[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // A masked edge is dropped here, so it can never reach the pending vector
  assign req_edge = sync_q[SYNC_STAGES-1] & ~sync_prev & mask;
  assign elig     = pending & mask;
  assign ack      = (state == OFFER) & irq_ready;

  // Pick the highest set index of the eligible vector (later hits override earlier)
  always_comb begin
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (elig[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // One-hot of the channel being acknowledged this cycle
  always_comb begin
    ack_vec = '0;
    if (ack) begin
      ack_vec[irq_id] = 1'b1;
    end
  end

  // Pending bits: a new edge wins over the acknowledge of the same channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~ack_vec) | req_edge;
    end
  end

  // Offer FSM: IDLE and CLEAR both start a new offer when something is eligible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE, CLEAR: begin
          if (elig != '0) begin
            state     <= OFFER;
            irq_valid <= 1'b1;
            irq_id    <= winner;
          end else begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end
        end
        OFFER: begin
          if (irq_ready) begin
            state     <= CLEAR;
            irq_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_OVERFLOW_EN
  // Sticky lost-event flags: repeat edge on a pending, un-acked channel sets; ack clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= '0;
    end else begin
      overflow <= (overflow & ~ack_vec) | (req_edge & pending & ~ack_vec);
    end
  end
`else
  assign overflow = '0;
`endif

endmodule
